// File: rtl/add_serial_sched.sv
// add_serial_sched
//   Round-robin scheduler sharing one serial adder among NREQ requesters.
//   Grants one requester at a time, launches the adder with a one-cycle
//   enable, waits for completion (or a timeout) and returns a tagged response.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_valid / o_req_ready  per-requester handshake (ready is one-hot)
//   i_req_a, i_req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   o_add_en                one-cycle launch pulse to the adder
//   o_add_a, o_add_b        latched operands, held until the next transfer
//   i_add_out, i_add_done   adder result and completion
//   o_rsp_valid             one-cycle response pulse
//   o_rsp_id, o_rsp_sum, o_rsp_err  response payload (sum is 0 on timeout)
//   o_busy                  scheduler is not idle
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | arbitrate; transfer operands from the granted requester
// LAUNCH | o_add_en high for this one cycle; arm the timeout counter
// WAIT   | wait for i_add_done or the timeout counter to expire
// RESP   | o_rsp_* presented; served requester becomes lowest priority
module add_serial_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  output logic                  o_add_en,
  output logic [WIDTH-1:0]      o_add_a,
  output logic [WIDTH-1:0]      o_add_b,
  input  logic [WIDTH-1:0]      i_add_out,
  input  logic                  i_add_done,
  output logic                  o_rsp_valid,
  output logic [$clog2(NREQ)-1:0] o_rsp_id,
  output logic [WIDTH-1:0]      o_rsp_sum,
  output logic                  o_rsp_err,
  output logic                  o_busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  r_id;
  logic [TW-1:0]   r_timer;

  logic            w_found;
  logic [IDW-1:0]  w_gid;
  logic [IDW:0]    w_cand;
  logic [NREQ-1:0] w_onehot;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  // Search starts one past the last served requester so it ends up with
  // lowest priority; the extra bit in w_cand absorbs the wrap before reduction.
  always_comb begin
    w_found  = 1'b0;
    w_gid    = '0;
    w_cand   = '0;
    w_onehot = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = {1'b0, r_last} + (IDW+1)'(k);
      if (w_cand >= (IDW+1)'(NREQ))
        w_cand = w_cand - (IDW+1)'(NREQ);
      if (!w_found && i_req_valid[w_cand[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gid   = w_cand[IDW-1:0];
      end
    end
    if (w_found)
      w_onehot[w_gid] = 1'b1;
  end

  assign w_sel_a = i_req_a[w_gid*WIDTH +: WIDTH];
  assign w_sel_b = i_req_b[w_gid*WIDTH +: WIDTH];

  // Ready is masked during reset so every output reads zero while rst is high.
  assign o_req_ready = (r_state == S_IDLE && !i_rst) ? w_onehot : '0;
  assign o_busy      = (r_state != S_IDLE);

  // The timeout counter counts down from TIMEOUT-1; reaching zero in WAIT
  // corresponds to the TIMEOUT-th WAIT cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_last      <= IDW'(NREQ-1);
      r_id        <= '0;
      r_timer     <= '0;
      o_add_en    <= 1'b0;
      o_add_a     <= '0;
      o_add_b     <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_sum   <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      o_add_en    <= 1'b0;
      o_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            o_add_a  <= w_sel_a;
            o_add_b  <= w_sel_b;
            r_id     <= w_gid;
            o_add_en <= 1'b1;
            r_state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_timer <= TW'(TIMEOUT-1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion is checked first so a done on the last cycle still succeeds.
          if (i_add_done) begin
            o_rsp_valid <= 1'b1;
            o_rsp_id    <= r_id;
            o_rsp_sum   <= i_add_out;
            o_rsp_err   <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_timer == '0) begin
            o_rsp_valid <= 1'b1;
            o_rsp_id    <= r_id;
            o_rsp_sum   <= '0;
            o_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_RESP: begin
          r_last  <= r_id;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
